// File: rtl/vend_pkg.sv
// ============================================================================
// Module   : vend_pkg
// Brief    : Shared encodings, states, coin values and price table for the
//            vending controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    localparam logic [2:0] ROM_ADD1   = 3'd0;
    localparam logic [2:0] ROM_ADD10  = 3'd1;
    localparam logic [2:0] ROM_ADD100 = 3'd2;
    localparam logic [2:0] ROM_CLEAR  = 3'd3;
    localparam logic [2:0] ROM_NOP    = 3'd4;

    localparam logic [9:0] COIN_1   = 10'd1;
    localparam logic [9:0] COIN_10  = 10'd10;
    localparam logic [9:0] COIN_100 = 10'd100;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_SETTLE   = 3'd2,
        S_CHECK    = 3'd3,
        S_DISPENSE = 3'd4,
        S_CLR      = 3'd5
    } state_t;

    localparam logic [9:0] PRICE [0:7] = '{
        10'd25, 10'd50, 10'd75, 10'd100, 10'd125, 10'd150, 10'd200, 10'd250
    };

    function automatic logic [9:0] price_of(input logic [2:0] item);
        return PRICE[item];
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_controller_op_timer.sv
// ============================================================================
// Module   : op_timer
// Brief    : Loadable down-counter; done pulses in the last counted cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q,  busy_d;

    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        if (load) begin
            count_d = load_val;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q == '0) begin
                busy_d = 1'b0;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign done = busy_q && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/vend_controller.sv
// ============================================================================
// Module   : vend_controller
// Brief    : Sequences coin/selection/cancel events into rom_num programs for
//            prog_calculator. Optional macro VEND_CHANGE_EN returns vend change.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_controller
    import vend_pkg::*;
#(
    parameter int PROG_LEN = 8,
    parameter int SETTLE   = 2,
    parameter int MAX_PAID = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_1,
    input  logic       coin_10,
    input  logic       coin_100,
    input  logic       sel_valid,
    input  logic [2:0] sel_item,
    input  logic       cancel,
    input  logic [9:0] paid,
    output logic [2:0] rom_num,
    output logic       ready,
    output logic       dispense,
    output logic [2:0] item_out,
    output logic [9:0] change,
    output logic       change_valid,
    output logic       short,
    output logic       reject
);

    localparam int         TIMER_W  = 8;
    localparam logic [10:0] MAX_SUM = 11'(MAX_PAID);
    localparam logic [TIMER_W-1:0] PROG_LOAD   = TIMER_W'(PROG_LEN - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE - 1);

    state_t      state_q,        state_d;
    logic [2:0]  op_q,           op_d;
    logic [2:0]  item_q,         item_d;
    logic [2:0]  rom_num_q,      rom_num_d;
    logic        ready_q,        ready_d;
    logic        dispense_q,     dispense_d;
    logic [2:0]  item_out_q,     item_out_d;
    logic [9:0]  change_q,       change_d;
    logic        change_valid_q, change_valid_d;
    logic        short_q,        short_d;
    logic        reject_q,       reject_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_done;

    logic        coin_hit;
    logic [9:0]  coin_val;
    logic [2:0]  coin_op;
    logic [10:0] coin_sum;
    logic [9:0]  price;

    op_timer #(.WIDTH(TIMER_W)) u_op_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Highest-value coin wins when several arrive together.
    always_comb begin
        coin_hit = 1'b1;
        coin_val = COIN_1;
        coin_op  = ROM_ADD1;
        if (coin_100) begin
            coin_val = COIN_100;
            coin_op  = ROM_ADD100;
        end else if (coin_10) begin
            coin_val = COIN_10;
            coin_op  = ROM_ADD10;
        end else if (!coin_1) begin
            coin_hit = 1'b0;
        end
    end

    assign coin_sum = {1'b0, paid} + {1'b0, coin_val};
    assign price    = price_of(item_q);

`ifdef VEND_CHANGE_EN
    logic [9:0] vend_diff;
    assign vend_diff = paid - price;
`endif

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        item_d         = item_q;
        item_out_d     = item_out_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        dispense_d     = 1'b0;
        short_d        = 1'b0;
        reject_d       = 1'b0;
        tmr_load       = 1'b0;
        tmr_val        = PROG_LOAD;

        unique case (state_q)
            S_IDLE: begin
                if (ready_q) begin
                    if (cancel) begin
                        if (paid != 10'd0) begin
                            change_d       = paid;
                            change_valid_d = 1'b1;
                            state_d        = S_CLR;
                            tmr_load       = 1'b1;
                        end
                    end else if (sel_valid) begin
                        item_d  = sel_item;
                        state_d = S_CHECK;
                    end else if (coin_hit) begin
                        if (coin_sum > MAX_SUM) begin
                            reject_d = 1'b1;
                        end else begin
                            op_d     = coin_op;
                            state_d  = S_RUN;
                            tmr_load = 1'b1;
                        end
                    end
                end
            end
            S_RUN, S_CLR: begin
                if (tmr_done) begin
                    state_d  = S_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (paid >= price) begin
                    state_d    = S_DISPENSE;
                    dispense_d = 1'b1;
                    item_out_d = item_q;
`ifdef VEND_CHANGE_EN
                    if (vend_diff != 10'd0) begin
                        change_d       = vend_diff;
                        change_valid_d = 1'b1;
                    end
`endif
                end else begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DISPENSE: begin
                state_d  = S_CLR;
                tmr_load = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered off the next state so they line up with it.
        rom_num_d = ROM_NOP;
        if (state_d == S_RUN) begin
            rom_num_d = op_d;
        end else if (state_d == S_CLR) begin
            rom_num_d = ROM_CLEAR;
        end
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            op_q           <= ROM_NOP;
            item_q         <= 3'd0;
            rom_num_q      <= ROM_NOP;
            ready_q        <= 1'b0;
            dispense_q     <= 1'b0;
            item_out_q     <= 3'd0;
            change_q       <= 10'd0;
            change_valid_q <= 1'b0;
            short_q        <= 1'b0;
            reject_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            item_q         <= item_d;
            rom_num_q      <= rom_num_d;
            ready_q        <= ready_d;
            dispense_q     <= dispense_d;
            item_out_q     <= item_out_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            short_q        <= short_d;
            reject_q       <= reject_d;
        end
    end

    assign rom_num      = rom_num_q;
    assign ready        = ready_q;
    assign dispense     = dispense_q;
    assign item_out     = item_out_q;
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign short        = short_q;
    assign reject       = reject_q;

endmodule

`default_nettype wire
